dta_rcv_protocol_checker: RTL and testbench

Parametrised, self-contained protocol checker for the ingress receive path of the direct transfer adaptor. It passively monitors the req, resp and data AXI4-Stream handshakes and tracks outstanding transactions in internal FIFOs. It flags protocol violations per cycle in the established 16-bit `protocol_error` format. It adds per-error masking, sticky capture with clear, a first-error record and a saturating error counter. It sits beside the receive datapath and drives no datapath signals.

---
 rtl/dta_rcv_protocol_checker_if.sv | 27 ++
 rtl/dta_rcv_protocol_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_dta_rcv_protocol_checker.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dta_rcv_protocol_checker_if.sv
// Receive-path AXI4-Stream bundle observed by the protocol checker:
// req and resp descriptor streams plus the data payload stream.
interface dta_rcv_protocol_checker_if #(
    parameter int DATA_W = 512
);
    logic              req_tvalid;
    logic              req_tready;
    logic [63:0]       req_tdata;
    logic              resp_tvalid;
    logic              resp_tready;
    logic [63:0]       resp_tdata;
    logic              data_tvalid;
    logic              data_tready;
    logic [DATA_W-1:0] data_tdata;

    modport master (
        output req_tvalid, req_tready, req_tdata,
        output resp_tvalid, resp_tready, resp_tdata,
        output data_tvalid, data_tready, data_tdata
    );

    modport slave (
        input req_tvalid, req_tready, req_tdata,
        input resp_tvalid, resp_tready, resp_tdata,
        input data_tvalid, data_tready, data_tdata
    );
endinterface

// File: rtl/dta_rcv_protocol_checker.sv
// Passive protocol checker for the direct transfer adaptor receive path.
// Tracks outstanding req descriptors and expected data bursts in two FIFOs,
// reports per-cycle violations and keeps sticky / first / count records.
//
// Beat tracker states:
//   state      | meaning
//   BEAT_IDLE  | no burst in progress; next data beat loads count from resp FIFO head
//   BEAT_BURST | burst in progress; beat_rem holds beats still expected for the head
module dta_rcv_protocol_checker #(
    parameter int DATA_W     = 512,
    parameter int NUM_CH     = 32,
    parameter int OUT_DEPTH  = 16,
    parameter int MAX_BURST  = 32768,
    parameter int STRICT_LEN = 1
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    dta_rcv_protocol_checker_if.slave      axis,
    input  logic [15:0]                    err_mask,
    input  logic                           err_clear,
    output logic [15:0]                    protocol_error,
    output logic                           protocol_error_ap_vld,
    output logic [15:0]                    error_sticky,
    output logic [15:0]                    first_error,
    output logic [15:0]                    error_count,
    output logic [$clog2(OUT_DEPTH):0]     req_outstanding,
    output logic [$clog2(OUT_DEPTH):0]     resp_outstanding
);
    localparam int PW  = $clog2(OUT_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BPB = DATA_W / 8;
    localparam int BSH = $clog2(BPB);
    localparam logic [CW-1:0] DEPTH_C   = CW'(OUT_DEPTH);
    // bits 4, 5, 14 and 15 are reserved and must always read 0
    localparam logic [15:0]   RSVD_KEEP = 16'h3FCF;

    typedef enum logic {BEAT_IDLE, BEAT_BURST} beat_state_t;

    // descriptor fields
    logic        req_fire, resp_fire, data_fire;
    logic [15:0] req_ch, req_len, resp_ch, resp_len;
    logic        req_sof, req_eof, resp_sof, resp_eof;
    logic [16:0] beats_wide;
    logic [15:0] resp_beats;

    // req FIFO: entry = {len, eof, sof, channel}
    logic [33:0]   rq_mem [OUT_DEPTH];
    logic [PW-1:0] rq_wr, rq_rd;
    logic [CW-1:0] rq_cnt;
    logic          rq_push, rq_pop, rq_empty, rq_full;
    logic [33:0]   rq_head;

    // resp FIFO: entry = expected data beats
    logic [15:0]   rs_mem [OUT_DEPTH];
    logic [PW-1:0] rs_wr, rs_rd;
    logic [CW-1:0] rs_cnt;
    logic          rs_push, rs_pop, rs_empty, rs_full;
    logic [15:0]   rs_head;

    beat_state_t beat_state, beat_state_next;
    logic [15:0] beat_rem, beat_rem_next, beat_cur;

    logic [15:0] err_raw, err_next;
    logic [15:0] sticky_base, first_base, count_base;
    logic [15:0] sticky_next, first_next, count_next;

    logic unused_bits;

    assign req_fire  = axis.req_tvalid  & axis.req_tready;
    assign resp_fire = axis.resp_tvalid & axis.resp_tready;
    assign data_fire = axis.data_tvalid & axis.data_tready;

    assign req_ch   = axis.req_tdata[15:0];
    assign req_sof  = axis.req_tdata[16];
    assign req_eof  = axis.req_tdata[17];
    assign req_len  = axis.req_tdata[63:48];
    assign resp_ch  = axis.resp_tdata[15:0];
    assign resp_sof = axis.resp_tdata[16];
    assign resp_eof = axis.resp_tdata[17];
    assign resp_len = axis.resp_tdata[63:48];

    // ceil(len / BPB) with one spare bit so the rounding add cannot wrap
    assign beats_wide = ({1'b0, resp_len} + 17'(BPB - 1)) >> BSH;
    assign resp_beats = beats_wide[15:0];

    assign rq_empty = (rq_cnt == '0);
    assign rq_full  = (rq_cnt == DEPTH_C);
    assign rs_empty = (rs_cnt == '0);
    assign rs_full  = (rs_cnt == DEPTH_C);
    assign rq_head  = rq_mem[rq_rd];
    assign rs_head  = rs_mem[rs_rd];

    assign req_outstanding  = rq_cnt;
    assign resp_outstanding = rs_cnt;

    assign unused_bits = ^{axis.req_tdata[47:18], axis.resp_tdata[47:18],
                           axis.data_tdata, beats_wide[16]};

    // Beat tracker state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_state <= BEAT_IDLE;
            beat_rem   <= '0;
        end else begin
            beat_state <= beat_state_next;
            beat_rem   <= beat_rem_next;
        end
    end

    // Handshake checks, FIFO push/pop decisions and beat tracker next state.
    // All checks use pre-cycle FIFO state, so an entry pushed this cycle is
    // only visible next cycle; a pop from a full FIFO frees room for a push.
    always_comb begin
        err_raw         = '0;
        rq_push         = 1'b0;
        rq_pop          = 1'b0;
        rs_push         = 1'b0;
        rs_pop          = 1'b0;
        beat_state_next = beat_state;
        beat_rem_next   = beat_rem;
        beat_cur        = (beat_state == BEAT_BURST) ? beat_rem : rs_head;

        if (data_fire) begin
            if (rs_empty) begin
                err_raw[9] = 1'b1;
            end else if (beat_cur <= 16'd1) begin
                rs_pop          = 1'b1;
                beat_state_next = BEAT_IDLE;
                beat_rem_next   = '0;
            end else begin
                beat_state_next = BEAT_BURST;
                beat_rem_next   = beat_cur - 16'd1;
            end
        end

        if (resp_fire) begin
            if (rq_empty) begin
                err_raw[7] = 1'b1;
            end else begin
                rq_pop     = 1'b1;
                err_raw[0] = (resp_ch  != rq_head[15:0]);
                err_raw[2] = (resp_sof != rq_head[16]);
                err_raw[3] = (resp_eof != rq_head[17]);
                // zero length marks a rejected request: no data will follow
                if (resp_len != 16'd0) begin
                    err_raw[1]  = (resp_len > rq_head[33:18]);
                    err_raw[13] = (STRICT_LEN != 0) && (resp_len != rq_head[33:18]);
                    if (rs_full && !rs_pop) begin
                        err_raw[11] = 1'b1;
                    end else begin
                        rs_push = 1'b1;
                    end
                end
            end
        end

        if (req_fire) begin
            err_raw[8]  = ({16'd0, req_len} > 32'(MAX_BURST));
            err_raw[12] = (req_len == 16'd0);
            err_raw[10] = ({16'd0, req_ch} >= 32'(NUM_CH));
            if (rq_full && !rq_pop) begin
                err_raw[6] = 1'b1;
            end else begin
                rq_push = 1'b1;
            end
        end

        err_next = err_raw & ~err_mask & RSVD_KEEP;
    end

    // Req FIFO pointers and occupancy
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rq_wr  <= '0;
            rq_rd  <= '0;
            rq_cnt <= '0;
        end else begin
            if (rq_push) rq_wr <= rq_wr + PW'(1);
            if (rq_pop)  rq_rd <= rq_rd + PW'(1);
            rq_cnt <= rq_cnt + CW'(rq_push) - CW'(rq_pop);
        end
    end

    // Resp FIFO pointers and occupancy
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rs_wr  <= '0;
            rs_rd  <= '0;
            rs_cnt <= '0;
        end else begin
            if (rs_push) rs_wr <= rs_wr + PW'(1);
            if (rs_pop)  rs_rd <= rs_rd + PW'(1);
            rs_cnt <= rs_cnt + CW'(rs_push) - CW'(rs_pop);
        end
    end

    // FIFO storage; contents are qualified by the occupancy counters
    always_ff @(posedge ap_clk) begin
        if (rq_push) rq_mem[rq_wr] <= {req_len, req_eof, req_sof, req_ch};
        if (rs_push) rs_mem[rs_wr] <= resp_beats;
    end

    // Record updates: clear applies first, a same-cycle error lands on top
    always_comb begin
        sticky_base = err_clear ? 16'd0 : error_sticky;
        first_base  = err_clear ? 16'd0 : first_error;
        count_base  = err_clear ? 16'd0 : error_count;
        sticky_next = sticky_base | err_next;
        first_next  = (first_base == 16'd0) ? err_next : first_base;
        count_next  = count_base;
        if ((err_next != 16'd0) && (count_base != 16'hFFFF)) begin
            count_next = count_base + 16'd1;
        end
    end

    // Error outputs and records
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            protocol_error        <= '0;
            protocol_error_ap_vld <= 1'b0;
            error_sticky          <= '0;
            first_error           <= '0;
            error_count           <= '0;
        end else begin
            protocol_error        <= err_next;
            protocol_error_ap_vld <= (err_next != 16'd0);
            error_sticky          <= sticky_next;
            first_error           <= first_next;
            error_count           <= count_next;
        end
    end
endmodule

// File: tb/tb_dta_rcv_protocol_checker.sv
// Self-checking bench for dta_rcv_protocol_checker: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_dta_rcv_protocol_checker;
    localparam int DATA_W = 512;
    localparam int D      = 16;
    localparam int BPB    = DATA_W / 8;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [15:0] err_mask;
    logic        err_clear;
    logic [15:0] protocol_error, error_sticky, first_error, error_count;
    logic        protocol_error_ap_vld;
    logic [4:0]  req_outstanding, resp_outstanding;

    always #5 ap_clk = ~ap_clk;

    dta_rcv_protocol_checker_if #(.DATA_W(DATA_W)) bus ();

    dta_rcv_protocol_checker #(
        .DATA_W(DATA_W), .NUM_CH(32), .OUT_DEPTH(D), .MAX_BURST(32768), .STRICT_LEN(1)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .axis(bus),
        .err_mask(err_mask),
        .err_clear(err_clear),
        .protocol_error(protocol_error),
        .protocol_error_ap_vld(protocol_error_ap_vld),
        .error_sticky(error_sticky),
        .first_error(first_error),
        .error_count(error_count),
        .req_outstanding(req_outstanding),
        .resp_outstanding(resp_outstanding)
    );

    // reference model state
    logic [63:0] m_req_q[$];
    int          m_resp_q[$];
    int          m_rem;
    logic [15:0] m_err, m_sticky, m_first, m_count;
    bit          r_rdy = 1, s_rdy = 1, d_rdy = 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] desc(input int ch, input bit sof, input bit eof, input int len);
        return {len[15:0], 30'd0, eof, sof, ch[15:0]};
    endfunction

    task automatic model_reset();
        m_req_q.delete();
        m_resp_q.delete();
        m_rem = 0;
        m_err = 0; m_sticky = 0; m_first = 0; m_count = 0;
    endtask

    // Drive one cycle at the negedge, advance the model, return at next negedge
    task automatic step(input bit rv, input logic [63:0] rd, input bit sv, input logic [63:0] sd,
                        input bit dv, input logic [15:0] mask, input bit clr);
        logic [15:0] e;
        logic [63:0] h;
        bus.req_tvalid  = rv;  bus.req_tready  = r_rdy; bus.req_tdata  = rd;
        bus.resp_tvalid = sv;  bus.resp_tready = s_rdy; bus.resp_tdata = sd;
        bus.data_tvalid = dv;  bus.data_tready = d_rdy;
        bus.data_tdata  = {16{$urandom()}};
        err_mask = mask; err_clear = clr;
        e = 0;
        if (dv && d_rdy) begin
            if (m_resp_q.size() == 0) e[9] = 1;
            else begin
                if (m_rem == 0) m_rem = m_resp_q[0];
                m_rem--;
                if (m_rem == 0) void'(m_resp_q.pop_front());
            end
        end
        if (sv && s_rdy) begin
            if (m_req_q.size() == 0) e[7] = 1;
            else begin
                h = m_req_q.pop_front();
                e[0] = h[15:0] != sd[15:0];
                e[2] = h[16] != sd[16];
                e[3] = h[17] != sd[17];
                if (sd[63:48] != 0) begin
                    e[1]  = sd[63:48] > h[63:48];
                    e[13] = sd[63:48] != h[63:48];
                    if (m_resp_q.size() >= D) e[11] = 1;
                    else m_resp_q.push_back((int'(sd[63:48]) + BPB - 1) / BPB);
                end
            end
        end
        if (rv && r_rdy) begin
            e[8]  = int'(rd[63:48]) > 32768;
            e[12] = rd[63:48] == 0;
            e[10] = int'(rd[15:0]) >= 32;
            if (m_req_q.size() >= D) e[6] = 1;
            else m_req_q.push_back(rd);
        end
        e = e & ~mask & 16'h3FCF;
        if (clr) begin m_sticky = 0; m_first = 0; m_count = 0; end
        m_sticky = m_sticky | e;
        if (m_first == 0) m_first = e;
        if (e != 0 && m_count != 16'hFFFF) m_count = m_count + 1;
        m_err = e;
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic test_reset();
        ap_rst_n = 0;
        r_rdy = 1; s_rdy = 1; d_rdy = 1;
        bus.req_tvalid = 0; bus.req_tready = 1; bus.req_tdata = 0;
        bus.resp_tvalid = 0; bus.resp_tready = 1; bus.resp_tdata = 0;
        bus.data_tvalid = 0; bus.data_tready = 1; bus.data_tdata = '0;
        err_mask = 0; err_clear = 0;
        model_reset();
        repeat (3) @(negedge ap_clk);
        checks++; if (protocol_error !== 16'h0) begin errors++; $display("FAIL reset_perr: got %h expected 0000", protocol_error); end
        checks++; if (protocol_error_ap_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", protocol_error_ap_vld); end
        checks++; if ({error_sticky, first_error, error_count} !== 48'h0) begin errors++; $display("FAIL reset_records: got %h expected 0", {error_sticky, first_error, error_count}); end
        checks++; if ({req_outstanding, resp_outstanding} !== 10'h0) begin errors++; $display("FAIL reset_occ: got %h expected 0", {req_outstanding, resp_outstanding}); end
        ap_rst_n = 1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        step(1, desc(3, 1, 1, 128), 0, 0, 0, 0, 0);
        checks++; if (req_outstanding !== 5'd1) begin errors++; $display("FAIL basic_reqocc: got %0d expected 1", req_outstanding); end
        step(0, 0, 1, desc(3, 1, 1, 128), 0, 0, 0);
        checks++; if (protocol_error !== 16'h0) begin errors++; $display("FAIL basic_resp_perr: got %h expected 0000", protocol_error); end
        checks++; if ({req_outstanding, resp_outstanding} !== {5'd0, 5'd1}) begin errors++; $display("FAIL basic_occ: got %0d/%0d expected 0/1", req_outstanding, resp_outstanding); end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (resp_outstanding !== 5'd1) begin errors++; $display("FAIL basic_beat1_occ: got %0d expected 1", resp_outstanding); end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (protocol_error !== 16'h0 || error_sticky !== 16'h0) begin errors++; $display("FAIL basic_beat2: got perr %h sticky %h expected 0000", protocol_error, error_sticky); end
        checks++; if (resp_outstanding !== 5'd0) begin errors++; $display("FAIL basic_resp_occ: got %0d expected 0", resp_outstanding); end
    endtask

    task automatic test_mismatch();
        step(1, desc(3, 1, 1, 128), 0, 0, 0, 0, 1);
        step(0, 0, 1, desc(4, 1, 1, 192), 0, 0, 0);
        checks++; if (protocol_error !== 16'h2003) begin errors++; $display("FAIL mism_perr: got %h expected 2003", protocol_error); end
        checks++; if (protocol_error_ap_vld !== 1'b1) begin errors++; $display("FAIL mism_vld: got %b expected 1", protocol_error_ap_vld); end
        checks++; if (first_error !== 16'h2003) begin errors++; $display("FAIL mism_first: got %h expected 2003", first_error); end
        idle();
        checks++; if (protocol_error !== 16'h0 || protocol_error_ap_vld !== 1'b0) begin errors++; $display("FAIL mism_oneshot: got %h/%b expected 0000/0", protocol_error, protocol_error_ap_vld); end
        checks++; if (error_count !== 16'd1 || error_sticky !== 16'h2003) begin errors++; $display("FAIL mism_records: got count %0d sticky %h expected 1/2003", error_count, error_sticky); end
        repeat (3) step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (resp_outstanding !== 5'd0 || protocol_error !== 16'h0) begin errors++; $display("FAIL mism_drain: got occ %0d perr %h expected 0/0000", resp_outstanding, protocol_error); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            step(1, desc(1, 0, 0, 64), 0, 0, 0, 0, i == 0);
            checks++;
            if (protocol_error !== ((i == 16) ? 16'h0040 : 16'h0000)) begin
                errors++; $display("FAIL ovf_perr[%0d]: got %h expected %h", i, protocol_error, (i == 16) ? 16'h0040 : 16'h0000);
            end
        end
        checks++; if (req_outstanding !== 5'd16) begin errors++; $display("FAIL ovf_occ: got %0d expected 16", req_outstanding); end
        repeat (16) step(0, 0, 1, desc(1, 0, 0, 0), 0, 0, 0);
        checks++; if ({req_outstanding, resp_outstanding} !== 10'h0) begin errors++; $display("FAIL ovf_drain: got %0d/%0d expected 0/0", req_outstanding, resp_outstanding); end
        checks++; if (error_sticky !== 16'h0040) begin errors++; $display("FAIL ovf_sticky: got %h expected 0040", error_sticky); end
    endtask

    task automatic test_clear();
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (protocol_error !== 16'h0200) begin errors++; $display("FAIL clr_nodata: got %h expected 0200", protocol_error); end
        step(1, desc(2, 1, 0, 0), 0, 0, 0, 0, 1);
        checks++; if (error_sticky !== 16'h1000) begin errors++; $display("FAIL clr_sticky: got %h expected 1000", error_sticky); end
        checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL clr_count: got %0d expected 1", error_count); end
        checks++; if (first_error !== 16'h1000) begin errors++; $display("FAIL clr_first: got %h expected 1000", first_error); end
        step(0, 0, 1, desc(2, 1, 0, 0), 0, 0, 0);
        checks++; if ({req_outstanding, resp_outstanding} !== 10'h0 || protocol_error !== 16'h0) begin errors++; $display("FAIL clr_drain: got occ %0d/%0d perr %h expected 0/0/0000", req_outstanding, resp_outstanding, protocol_error); end
    endtask

    task automatic test_mask();
        step(1, desc(5, 0, 1, 0), 0, 0, 0, 16'h1000, 1);
        checks++; if ({protocol_error, protocol_error_ap_vld} !== 17'h0) begin errors++; $display("FAIL mask_perr: got %h/%b expected 0000/0", protocol_error, protocol_error_ap_vld); end
        checks++; if ({error_sticky, first_error, error_count} !== 48'h0) begin errors++; $display("FAIL mask_records: got %h expected 0", {error_sticky, first_error, error_count}); end
        checks++; if (req_outstanding !== 5'd1) begin errors++; $display("FAIL mask_pushed: got %0d expected 1", req_outstanding); end
        step(0, 0, 1, desc(5, 0, 1, 0), 0, 16'h1000, 0);
        checks++; if (resp_outstanding !== 5'd0 || protocol_error !== 16'h0) begin errors++; $display("FAIL mask_resp: got occ %0d perr %h expected 0/0000", resp_outstanding, protocol_error); end
        step(0, 0, 0, 0, 1, 16'h1000, 0);
        checks++; if (protocol_error !== 16'h0200) begin errors++; $display("FAIL mask_data: got %h expected 0200", protocol_error); end
    endtask

    task automatic test_same_cycle();
        step(1, desc(6, 1, 1, 64), 1, desc(6, 1, 1, 64), 0, 0, 1);
        checks++; if (protocol_error !== 16'h0080 || req_outstanding !== 5'd1) begin errors++; $display("FAIL same_req_resp: got perr %h occ %0d expected 0080/1", protocol_error, req_outstanding); end
        repeat (15) step(1, desc(6, 1, 1, 64), 0, 0, 0, 0, 0);
        step(1, desc(6, 1, 1, 64), 1, desc(6, 1, 1, 64), 0, 0, 0);
        checks++; if (protocol_error !== 16'h0 || req_outstanding !== 5'd16) begin errors++; $display("FAIL full_popush_req: got perr %h occ %0d expected 0000/16", protocol_error, req_outstanding); end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, desc(6, 1, 1, 64), 0, 0, 0);
            checks++;
            if (protocol_error !== ((i == 15) ? 16'h0800 : 16'h0000)) begin
                errors++; $display("FAIL respovf_perr[%0d]: got %h expected %h", i, protocol_error, (i == 15) ? 16'h0800 : 16'h0000);
            end
        end
        step(1, desc(6, 1, 1, 64), 0, 0, 0, 0, 0);
        step(0, 0, 1, desc(6, 1, 1, 64), 1, 0, 0);
        checks++; if (protocol_error !== 16'h0 || resp_outstanding !== 5'd16) begin errors++; $display("FAIL full_popush_resp: got perr %h occ %0d expected 0000/16", protocol_error, resp_outstanding); end
        repeat (16) step(0, 0, 0, 0, 1, 0, 0);
        step(1, desc(6, 1, 1, 64), 0, 0, 0, 0, 0);
        step(0, 0, 1, desc(6, 1, 1, 64), 1, 0, 0);
        checks++; if (protocol_error !== 16'h0200 || resp_outstanding !== 5'd1) begin errors++; $display("FAIL same_resp_data: got perr %h occ %0d expected 0200/1", protocol_error, resp_outstanding); end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if ({req_outstanding, resp_outstanding} !== 10'h0) begin errors++; $display("FAIL same_drain: got %0d/%0d expected 0/0", req_outstanding, resp_outstanding); end
    endtask

    task automatic test_random();
        logic [63:0] rd, sd;
        bit rv, sv, dv, clr;
        logic [15:0] mask;
        int len, ch;
        for (int c = 0; c < 1500; c++) begin
            r_rdy = ($urandom % 4) != 0;
            s_rdy = ($urandom % 4) != 0;
            d_rdy = ($urandom % 4) != 0;
            rv = ($urandom % 3) == 0;
            ch = (($urandom % 8) == 0) ? int'($urandom_range(32, 40)) : int'($urandom_range(0, 31));
            case ($urandom % 16)
                0: len = 0;
                1: len = 32768 + int'($urandom_range(1, 1000));
                2: len = 32768;
                default: len = int'($urandom_range(1, 300));
            endcase
            rd = desc(ch, $urandom % 2, $urandom % 2, len);
            sv = ($urandom % 3) == 0;
            if (m_req_q.size() > 0 && ($urandom % 6) != 0) begin
                sd = m_req_q[0];
                if (($urandom % 5) == 0) sd[63:48] = 0;
                if (($urandom % 7) == 0) sd[63:48] = sd[63:48] + 16'($urandom_range(1, 80));
                if (($urandom % 9) == 0) sd[15:0] = sd[15:0] ^ 16'h1;
                if (($urandom % 11) == 0) sd[17:16] = ~sd[17:16];
            end else begin
                sd = desc($urandom_range(0, 31), $urandom % 2, $urandom % 2, $urandom_range(0, 300));
            end
            dv = ($urandom % 2) == 0;
            mask = (($urandom % 10) == 0) ? 16'($urandom) : 16'h0;
            clr = ($urandom % 25) == 0;
            step(rv, rd, sv, sd, dv, mask, clr);
            checks++; if (protocol_error !== m_err) begin errors++; $display("FAIL rnd_perr c%0d: got %h expected %h", c, protocol_error, m_err); end
            checks++; if (protocol_error_ap_vld !== (m_err != 0)) begin errors++; $display("FAIL rnd_vld c%0d: got %b expected %b", c, protocol_error_ap_vld, m_err != 0); end
            checks++; if (error_sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky c%0d: got %h expected %h", c, error_sticky, m_sticky); end
            checks++; if (first_error !== m_first) begin errors++; $display("FAIL rnd_first c%0d: got %h expected %h", c, first_error, m_first); end
            checks++; if (error_count !== m_count) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, error_count, m_count); end
            checks++; if (req_outstanding !== 5'(m_req_q.size())) begin errors++; $display("FAIL rnd_reqocc c%0d: got %0d expected %0d", c, req_outstanding, m_req_q.size()); end
            checks++; if (resp_outstanding !== 5'(m_resp_q.size())) begin errors++; $display("FAIL rnd_respocc c%0d: got %0d expected %0d", c, resp_outstanding, m_resp_q.size()); end
        end
        r_rdy = 1; s_rdy = 1; d_rdy = 1;
    endtask

    task automatic test_reset_mid();
        step(1, desc(7, 1, 1, 64), 0, 0, 0, 0, 0);
        step(1, desc(7, 1, 1, 64), 1, desc(7, 1, 1, 64), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        bus.req_tvalid = 0; bus.resp_tvalid = 0; bus.data_tvalid = 0;
        ap_rst_n = 0;
        #1;
        checks++; if ({req_outstanding, resp_outstanding} !== 10'h0) begin errors++; $display("FAIL rstmid_occ: got %0d/%0d expected 0/0", req_outstanding, resp_outstanding); end
        checks++; if ({protocol_error, error_sticky, first_error, error_count} !== 64'h0) begin errors++; $display("FAIL rstmid_out: got %h expected 0", {protocol_error, error_sticky, first_error, error_count}); end
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1;
        step(0, 0, 1, desc(7, 1, 1, 64), 0, 0, 0);
        checks++; if (protocol_error !== 16'h0080) begin errors++; $display("FAIL rstmid_resp: got %h expected 0080", protocol_error); end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (protocol_error !== 16'h0200 || error_count !== 16'd2) begin errors++; $display("FAIL rstmid_data: got %h count %0d expected 0200/2", protocol_error, error_count); end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 0, 1, 0, 1);
        for (int i = 1; i < 32'h10000; i++) step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (error_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count: got %h expected ffff", error_count); end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++; if (error_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", error_count); end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++; if (error_count !== 16'h0 || error_sticky !== 16'h0) begin errors++; $display("FAIL sat_clear: got count %h sticky %h expected 0/0", error_count, error_sticky); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_overflow();
        test_clear();
        test_mask();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
